// File: rtl/mat_mul_loader_if.sv
// AXI-Stream style beat bus shared by the loader's upstream and downstream
// ports. A beat transfers on a rising clock edge where tvalid and tready are
// both high; once tvalid is raised, tdata/tlast stay stable until accepted.
interface mat_mul_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mat_mul_loader.sv
// mat_mul_loader: feeds one job (matrix A then matrix B, N*N words each,
// row-major) into mat_mul through a 2-entry registered skid buffer, drives
// sel per matrix, regenerates tlast at the end of each matrix, pulses start
// after B has been delivered, and waits for res_last before the next job.
// Optional feature macro: MAT_LOADER_TLAST_CHECK_EN enables a sticky
// err_tlast flag for upstream tlast markers on the wrong beat.
module mat_mul_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_LOG    = 6
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  mat_mul_loader_if.slave       s00_axis,
  mat_mul_loader_if.master      m00_axis,
  output logic                  sel,
  output logic                  start,
  input  logic                  res_last,
  output logic                  busy,
  output logic                  err_tlast,
  output logic [1:0]            dbg_state
);

  localparam int CW = 2 * DIM_LOG + 1;
  localparam logic [CW-1:0] N2       = {1'b1, {(2 * DIM_LOG){1'b0}}};
  localparam logic [CW-1:0] LAST_IDX = N2 - CW'(1);

  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    START    = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         in_cnt;
  logic [CW-1:0]         out_cnt;

  // o_* is the output register seen on m00, k_* is the skid register
  logic                  o_valid;
  logic                  o_last;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  k_valid;
  logic                  k_last;
  logic [DATA_WIDTH-1:0] k_data;

  logic                  loading;
  logic                  in_open;
  logic                  in_fire;
  logic                  out_fire;
  logic                  in_last;
  logic                  mat_done;

  assign loading  = (state == LOAD_A) || (state == LOAD_B);
  // gated by reset so the upstream never sees ready while reset is held
  assign in_open  = s00_axi_aresetn & loading & (in_cnt < N2) & ~(o_valid & k_valid);
  assign in_fire  = s00_axis.tvalid & in_open;
  assign out_fire = o_valid & m00_axis.tready;
  assign in_last  = (in_cnt == LAST_IDX);
  // final beat of the current matrix leaves this cycle; the buffer is then
  // empty because the input closed after N*N accepted beats
  assign mat_done = out_fire & (out_cnt == LAST_IDX);

  assign s00_axis.tready = in_open;
  assign m00_axis.tvalid = o_valid;
  assign m00_axis.tdata  = o_data;
  assign m00_axis.tlast  = o_last;
  assign busy            = ~((state == LOAD_A) && (in_cnt == '0));
  assign dbg_state       = state;

  // job sequencing: matrix counters, sel and the one-cycle start pulse
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state   <= LOAD_A;
      in_cnt  <= '0;
      out_cnt <= '0;
      sel     <= 1'b0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        LOAD_A, LOAD_B: begin
          if (mat_done) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            if (state == LOAD_A) begin
              state <= LOAD_B;
              sel   <= 1'b1;
            end else begin
              state <= START;
              start <= 1'b1;
            end
          end else begin
            if (in_fire)  in_cnt  <= in_cnt + CW'(1);
            if (out_fire) out_cnt <= out_cnt + CW'(1);
          end
        end
        START: state <= WAIT_RES;
        WAIT_RES: begin
          if (res_last) begin
            state   <= LOAD_A;
            sel     <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  // skid buffer: refill the output register from skid first to keep order
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
      k_valid <= 1'b0;
      k_last  <= 1'b0;
      k_data  <= '0;
    end else if (out_fire || !o_valid) begin
      if (k_valid) begin
        o_valid <= 1'b1;
        o_data  <= k_data;
        o_last  <= k_last;
        if (in_fire) begin
          k_data <= s00_axis.tdata;
          k_last <= in_last;
        end else begin
          k_valid <= 1'b0;
        end
      end else if (in_fire) begin
        o_valid <= 1'b1;
        o_data  <= s00_axis.tdata;
        o_last  <= in_last;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (in_fire) begin
      k_valid <= 1'b1;
      k_data  <= s00_axis.tdata;
      k_last  <= in_last;
    end
  end

`ifdef MAT_LOADER_TLAST_CHECK_EN
  // sticky flag: upstream tlast disagrees with the matrix beat index
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      err_tlast <= 1'b0;
    end else if (in_fire && (s00_axis.tlast != in_last)) begin
      err_tlast <= 1'b1;
    end
  end
`else
  assign err_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_mat_mul_loader.sv
// Bench for mat_mul_loader with DIM_LOG=2 (16 beats per matrix). The driver
// pushes {sel, tlast, tdata} expectations when an input beat is accepted; a
// negedge monitor pops and compares on every m00 handshake and also checks
// stall stability and start timing.
module tb_mat_mul_loader;
  localparam int DW = 32;
  localparam int W  = DW + 2;
`ifdef MAT_LOADER_TLAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mat_mul_loader_if #(.DATA_WIDTH(DW)) s_if ();
  mat_mul_loader_if #(.DATA_WIDTH(DW)) m_if ();
  logic       sel, start, res_last, busy, err_tlast;
  logic [1:0] dbg_state;

  mat_mul_loader #(.DATA_WIDTH(DW), .DIM_LOG(2)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axis        (s_if),
    .m00_axis        (m_if),
    .sel             (sel),
    .start           (start),
    .res_last        (res_last),
    .busy            (busy),
    .err_tlast       (err_tlast),
    .dbg_state       (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int  ready_mode = 0;
  bit  start_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // downstream ready: always high, or toggling every cycle
  initial m_if.tready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) m_if.tready = ~m_if.tready;
    else m_if.tready = 1'b1;
  end

  // scoreboard monitor
  logic         prev_stall = 1'b0;
  logic         start_due  = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    act = {sel, m_if.tlast, m_if.tdata};
    if (!rst_n) begin
      prev_stall = 1'b0;
      start_due  = 1'b0;
    end else begin
      if (start_due || start) chk("start_pulse", start, start_due);
      if (start) start_seen = 1;
      start_due = 1'b0;
      if (prev_stall) begin
        chk("stall_hold_valid", m_if.tvalid, 1);
        chk("stall_hold_word", act, held);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("m00_word", act, e);
          start_due = e[W-1] & e[W-2];
        end
      end
      prev_stall = m_if.tvalid & ~m_if.tready;
      held = act;
    end
  end

  // driver: present one beat, wait for acceptance (caller at posedge+1)
  task automatic send_beat(input logic [DW-1:0] d, input logic tl, input logic [W-1:0] e);
    bit done = 0;
    int n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = tl;
    while (!done && n < 200) begin
      @(negedge clk);
      if (s_if.tready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("input_accept_timeout", 0, 1);
  endtask

  task automatic run_job(input int base_a, input int base_b, input int nbeats, input int err_idx);
    for (int i = 0; i < nbeats; i++) begin
      logic [DW-1:0] d;
      logic          tl, lst;
      d   = (i < 16) ? DW'(base_a + i) : DW'(base_b + i - 16);
      lst = ((i % 16) == 15);
      tl  = lst || (i == err_idx);
      send_beat(d, tl, {(i >= 16), lst, d});
      if (err_idx >= 0 && (i == err_idx - 1 || i == err_idx))
        chk("err_tlast", err_tlast, (i >= err_idx) ? EXP_ERR : 1'b0);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // wait for start, confirm the loader holds off, then release with res_last
  task automatic finish_job();
    int n = 0;
    while (!start_seen && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (!start_seen) chk("start_timeout", 0, 1);
    repeat (4) begin
      @(negedge clk);
      chk("wait_tready", s_if.tready, 0);
      chk("wait_busy", busy, 1);
      chk("wait_state", dbg_state, 3);
    end
    @(posedge clk); #1;
    res_last = 1'b1;
    @(posedge clk); #1;
    res_last = 1'b0;
    chk("after_res_state", dbg_state, 0);
    chk("after_res_busy", busy, 0);
    chk("after_res_sel", sel, 0);
    start_seen = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_sel", sel, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tlast, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    res_last    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // continuous job, downstream always ready
    ready_mode = 0;
    run_job(1, 101, 32, -1);
    finish_job();

    // same job with downstream ready toggling every cycle
    ready_mode = 1;
    run_job(1, 101, 32, -1);
    finish_job();
    ready_mode = 0;

    // res_last while idle in LOAD_A must be ignored
    @(posedge clk); #1;
    res_last = 1'b1;
    @(posedge clk); #1;
    res_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_res_state", dbg_state, 0);
    chk("idle_res_busy", busy, 0);
    chk("idle_res_tready", s_if.tready, 1);

    // reset after 7 A beats, then a fresh job 1..32
    run_job(1, 101, 7, -1);
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    exp_q.delete();
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1, 17, 32, -1);
    finish_job();

    // upstream tlast on beat 10 (index 9)
    run_job(1, 101, 32, 9);
    finish_job();
    chk("err_sticky", err_tlast, EXP_ERR);

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
